// File: rtl/csrfile_if.sv
// Execute read port plus commit read/write channels of the machine-mode CSR file.
// The core's commit/execute side is the master; csrfile is the slave.
interface csrfile_if #(
   parameter int CSR_ADDR_WIDTH         = 12,
   parameter int REG_DATA_WIDTH         = 32,
   parameter int COMMIT_CSR_CHANNEL_NUM = 4
);
   logic [CSR_ADDR_WIDTH-1:0]         excsr_csrf_addr;
   logic [REG_DATA_WIDTH-1:0]         csrf_excsr_data;
   logic [CSR_ADDR_WIDTH-1:0]         commit_csrf_read_addr  [0:COMMIT_CSR_CHANNEL_NUM-1];
   logic [REG_DATA_WIDTH-1:0]         csrf_commit_read_data  [0:COMMIT_CSR_CHANNEL_NUM-1];
   logic [CSR_ADDR_WIDTH-1:0]         commit_csrf_write_addr [0:COMMIT_CSR_CHANNEL_NUM-1];
   logic [REG_DATA_WIDTH-1:0]         commit_csrf_write_data [0:COMMIT_CSR_CHANNEL_NUM-1];
   logic [COMMIT_CSR_CHANNEL_NUM-1:0] commit_csrf_we;

   modport master (
      output excsr_csrf_addr, commit_csrf_read_addr, commit_csrf_write_addr,
             commit_csrf_write_data, commit_csrf_we,
      input  csrf_excsr_data, csrf_commit_read_data
   );

   modport slave (
      input  excsr_csrf_addr, commit_csrf_read_addr, commit_csrf_write_addr,
             commit_csrf_write_data, commit_csrf_we,
      output csrf_excsr_data, csrf_commit_read_data
   );
endinterface

// File: rtl/csrfile.sv
// Machine-mode CSR file: trap/interrupt state, 64-bit cycle/instret counters and
// thirteen event counters, with combinational reads and masked commit writes.
module csrfile #(
   parameter int CSR_ADDR_WIDTH         = 12,
   parameter int REG_DATA_WIDTH         = 32,
   parameter int COMMIT_CSR_CHANNEL_NUM = 4,
   parameter int COMMIT_WIDTH           = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   csrfile_if.slave                          bus,
   input  logic [REG_DATA_WIDTH-1:0]         intif_csrf_mip_data,
   output logic [REG_DATA_WIDTH-1:0]         csrf_all_mie_data,
   output logic [REG_DATA_WIDTH-1:0]         csrf_all_mstatus_data,
   output logic [REG_DATA_WIDTH-1:0]         csrf_all_mip_data,
   output logic [REG_DATA_WIDTH-1:0]         csrf_all_mepc_data,
   input  logic                              fetch_csrf_checkpoint_buffer_full_add,
   input  logic                              fetch_csrf_fetch_not_full_add,
   input  logic                              fetch_csrf_fetch_decode_fifo_full_add,
   input  logic                              decode_csrf_decode_rename_fifo_full_add,
   input  logic                              rename_csrf_phy_regfile_full_add,
   input  logic                              rename_csrf_rob_full_add,
   input  logic                              issue_csrf_issue_execute_fifo_full_add,
   input  logic                              issue_csrf_issue_queue_full_add,
   input  logic                              commit_csrf_branch_num_add,
   input  logic                              commit_csrf_branch_predicted_add,
   input  logic                              commit_csrf_branch_hit_add,
   input  logic                              commit_csrf_branch_miss_add,
   input  logic                              ras_csrf_ras_full_add,
   input  logic [$clog2(COMMIT_WIDTH+1)-1:0] commit_csrf_commit_num_add
);
   localparam int A = CSR_ADDR_WIDTH;
   localparam int D = REG_DATA_WIDTH;

   localparam logic [A-1:0] ADDR_MSTATUS  = A'(12'h300);
   localparam logic [A-1:0] ADDR_MISA     = A'(12'h301);
   localparam logic [A-1:0] ADDR_MIE      = A'(12'h304);
   localparam logic [A-1:0] ADDR_MTVEC    = A'(12'h305);
   localparam logic [A-1:0] ADDR_MSCRATCH = A'(12'h340);
   localparam logic [A-1:0] ADDR_MEPC     = A'(12'h341);
   localparam logic [A-1:0] ADDR_MCAUSE   = A'(12'h342);
   localparam logic [A-1:0] ADDR_MTVAL    = A'(12'h343);
   localparam logic [A-1:0] ADDR_MIP      = A'(12'h344);
   localparam logic [A-1:0] ADDR_MCYCLE   = A'(12'hB00);
   localparam logic [A-1:0] ADDR_MINSTRET = A'(12'hB02);
   localparam logic [A-1:0] ADDR_MCYCLEH  = A'(12'hB80);
   localparam logic [A-1:0] ADDR_MINSTRH  = A'(12'hB82);
   localparam logic [A-1:0] ADDR_CYCLE    = A'(12'hC00);
   localparam logic [A-1:0] ADDR_INSTRET  = A'(12'hC02);
   localparam logic [A-1:0] ADDR_CYCLEH   = A'(12'hC80);
   localparam logic [A-1:0] ADDR_INSTRETH = A'(12'hC82);
   localparam logic [D-1:0] INT_MASK      = D'(32'h0000_0888);
   localparam logic [D-1:0] MISA_VALUE    = D'(32'h4000_1100);

   logic          mstatus_mie_reg, mstatus_mpie_reg;
   logic [D-1:0]  mie_reg, mtvec_reg, mscratch_reg, mepc_reg, mcause_reg, mtval_reg, mip_reg;
   logic [63:0]   mcycle_reg, minstret_reg;
   logic [63:0]   mcycle_next, minstret_next, mcycle_inc, minstret_inc;
   logic [D-1:0]  mstatus_val;
   logic [D-1:0]  hpm_val [0:15];
   logic [15:0]   hpm_evt;

   logic          mstatus_we, mie_we, mtvec_we, mscratch_we, mepc_we, mcause_we, mtval_we;
   logic          mcycle_lo_we, mcycle_hi_we, minstret_lo_we, minstret_hi_we;
   logic [D-1:0]  mstatus_wd, mie_wd, mtvec_wd, mscratch_wd, mepc_wd, mcause_wd, mtval_wd;
   logic [D-1:0]  mcycle_lo_wd, mcycle_hi_wd, minstret_lo_wd, minstret_hi_wd;

   // Scans channels in ascending order so the highest-index writer of a CSR wins.
   function automatic logic [D:0] wr_pick(input logic [A-1:0] target);
      logic [D:0] r;
      r = '0;
      for (int i = 0; i < COMMIT_CSR_CHANNEL_NUM; i++) begin
         if (bus.commit_csrf_we[i] && bus.commit_csrf_write_addr[i] == target)
            r = {1'b1, bus.commit_csrf_write_data[i]};
      end
      return r;
   endfunction

   always_comb begin
      {mstatus_we,     mstatus_wd}     = wr_pick(ADDR_MSTATUS);
      {mie_we,         mie_wd}         = wr_pick(ADDR_MIE);
      {mtvec_we,       mtvec_wd}       = wr_pick(ADDR_MTVEC);
      {mscratch_we,    mscratch_wd}    = wr_pick(ADDR_MSCRATCH);
      {mepc_we,        mepc_wd}        = wr_pick(ADDR_MEPC);
      {mcause_we,      mcause_wd}      = wr_pick(ADDR_MCAUSE);
      {mtval_we,       mtval_wd}       = wr_pick(ADDR_MTVAL);
      {mcycle_lo_we,   mcycle_lo_wd}   = wr_pick(ADDR_MCYCLE);
      {mcycle_hi_we,   mcycle_hi_wd}   = wr_pick(ADDR_MCYCLEH);
      {minstret_lo_we, minstret_lo_wd} = wr_pick(ADDR_MINSTRET);
      {minstret_hi_we, minstret_hi_wd} = wr_pick(ADDR_MINSTRH);
   end

   // The high half takes its carry from the pre-write low half, even when the low half is written.
   always_comb begin
      mcycle_inc    = mcycle_reg + 64'd1;
      minstret_inc  = minstret_reg + 64'(commit_csrf_commit_num_add);
      mcycle_next   = {mcycle_hi_we   ? mcycle_hi_wd   : mcycle_inc[63:32],
                       mcycle_lo_we   ? mcycle_lo_wd   : mcycle_inc[31:0]};
      minstret_next = {minstret_hi_we ? minstret_hi_wd : minstret_inc[63:32],
                       minstret_lo_we ? minstret_lo_wd : minstret_inc[31:0]};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mstatus_mie_reg  <= 1'b0;
         mstatus_mpie_reg <= 1'b0;
         mie_reg          <= '0;
         mtvec_reg        <= '0;
         mscratch_reg     <= '0;
         mepc_reg         <= '0;
         mcause_reg       <= '0;
         mtval_reg        <= '0;
         mip_reg          <= '0;
         mcycle_reg       <= '0;
         minstret_reg     <= '0;
      end else begin
         if (mstatus_we) begin
            mstatus_mie_reg  <= mstatus_wd[3];
            mstatus_mpie_reg <= mstatus_wd[7];
         end
         if (mie_we)      mie_reg      <= mie_wd & INT_MASK;
         if (mtvec_we)    mtvec_reg    <= mtvec_wd;
         if (mscratch_we) mscratch_reg <= mscratch_wd;
         if (mepc_we)     mepc_reg     <= {mepc_wd[D-1:2], 2'b00};
         if (mcause_we)   mcause_reg   <= mcause_wd;
         if (mtval_we)    mtval_reg    <= mtval_wd;
         mip_reg      <= intif_csrf_mip_data & INT_MASK;
         mcycle_reg   <= mcycle_next;
         minstret_reg <= minstret_next;
      end
   end

   assign hpm_evt = {ras_csrf_ras_full_add,
                     commit_csrf_branch_miss_add, commit_csrf_branch_hit_add,
                     commit_csrf_branch_predicted_add, commit_csrf_branch_num_add,
                     issue_csrf_issue_queue_full_add, issue_csrf_issue_execute_fifo_full_add,
                     rename_csrf_rob_full_add, rename_csrf_phy_regfile_full_add,
                     decode_csrf_decode_rename_fifo_full_add,
                     fetch_csrf_fetch_decode_fifo_full_add, fetch_csrf_fetch_not_full_add,
                     fetch_csrf_checkpoint_buffer_full_add, 3'b000};

   // Slots 0..2 of hpm_val stay zero so the read decode can index by address[3:0].
   for (genvar gi = 0; gi < 16; gi++) begin : g_hpm
      if (gi < 3) begin : g_none
         assign hpm_val[gi] = '0;
      end else begin : g_ctr
         logic         we;
         logic [D-1:0] wd;
         logic [D-1:0] cnt_reg;
         always_comb {we, wd} = wr_pick(ADDR_MCYCLE + A'(gi));
         always_ff @(posedge clk or posedge rst) begin
            if (rst)            cnt_reg <= '0;
            else if (we)        cnt_reg <= wd;
            else if (hpm_evt[gi]) cnt_reg <= cnt_reg + D'(1);
         end
         assign hpm_val[gi] = cnt_reg;
      end
   end

   assign mstatus_val = D'({19'b0, 2'b11, 3'b0, mstatus_mpie_reg, 3'b0, mstatus_mie_reg, 3'b0});

   function automatic logic [D-1:0] csr_read(input logic [A-1:0] a);
      logic [D-1:0] r;
      r = '0;
      case (a)
         ADDR_MSTATUS:               r = mstatus_val;
         ADDR_MISA:                  r = MISA_VALUE;
         ADDR_MIE:                   r = mie_reg;
         ADDR_MTVEC:                 r = mtvec_reg;
         ADDR_MSCRATCH:              r = mscratch_reg;
         ADDR_MEPC:                  r = mepc_reg;
         ADDR_MCAUSE:                r = mcause_reg;
         ADDR_MTVAL:                 r = mtval_reg;
         ADDR_MIP:                   r = mip_reg;
         ADDR_MCYCLE,   ADDR_CYCLE:    r = mcycle_reg[31:0];
         ADDR_MCYCLEH,  ADDR_CYCLEH:   r = mcycle_reg[63:32];
         ADDR_MINSTRET, ADDR_INSTRET:  r = minstret_reg[31:0];
         ADDR_MINSTRH,  ADDR_INSTRETH: r = minstret_reg[63:32];
         default: begin
            if (a[A-1:4] == ADDR_MCYCLE[A-1:4]) r = hpm_val[a[3:0]];
         end
      endcase
      return r;
   endfunction

   always_comb begin
      bus.csrf_excsr_data = csr_read(bus.excsr_csrf_addr);
      for (int i = 0; i < COMMIT_CSR_CHANNEL_NUM; i++)
         bus.csrf_commit_read_data[i] = csr_read(bus.commit_csrf_read_addr[i]);
   end

   assign csrf_all_mstatus_data = mstatus_val;
   assign csrf_all_mie_data     = mie_reg;
   assign csrf_all_mip_data     = mip_reg;
   assign csrf_all_mepc_data    = mepc_reg;
endmodule

// File: tb/tb_csrfile.sv
// Directed plus randomized bench for csrfile, checked against an address-indexed
// behavioural model of the CSR rules.
module tb_csrfile;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] intif_mip;
   logic [12:0] evt;
   logic [2:0]  commit_num;
   logic [31:0] all_mie, all_mstatus, all_mip, all_mepc;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   csrfile_if bus ();

   csrfile dut (
      .clk(clk), .rst(rst), .bus(bus),
      .intif_csrf_mip_data(intif_mip),
      .csrf_all_mie_data(all_mie), .csrf_all_mstatus_data(all_mstatus),
      .csrf_all_mip_data(all_mip), .csrf_all_mepc_data(all_mepc),
      .fetch_csrf_checkpoint_buffer_full_add(evt[0]),
      .fetch_csrf_fetch_not_full_add(evt[1]),
      .fetch_csrf_fetch_decode_fifo_full_add(evt[2]),
      .decode_csrf_decode_rename_fifo_full_add(evt[3]),
      .rename_csrf_phy_regfile_full_add(evt[4]),
      .rename_csrf_rob_full_add(evt[5]),
      .issue_csrf_issue_execute_fifo_full_add(evt[6]),
      .issue_csrf_issue_queue_full_add(evt[7]),
      .commit_csrf_branch_num_add(evt[8]),
      .commit_csrf_branch_predicted_add(evt[9]),
      .commit_csrf_branch_hit_add(evt[10]),
      .commit_csrf_branch_miss_add(evt[11]),
      .ras_csrf_ras_full_add(evt[12]),
      .commit_csrf_commit_num_add(commit_num)
   );

   // Reference model: plain registers indexed by CSR address, counters as 64-bit integers.
   logic [31:0] m_reg [0:4095];
   logic [63:0] m_mcycle, m_minstret;

   function automatic void m_reset();
      for (int a = 0; a < 4096; a++) m_reg[a] = '0;
      m_reg[12'h300] = 32'h0000_1800;
      m_mcycle   = '0;
      m_minstret = '0;
   endfunction

   function automatic logic [31:0] m_read(input logic [11:0] a);
      case (a)
         12'h301:          return 32'h4000_1100;
         12'hB00, 12'hC00: return m_mcycle[31:0];
         12'hB80, 12'hC80: return m_mcycle[63:32];
         12'hB02, 12'hC02: return m_minstret[31:0];
         12'hB82, 12'hC82: return m_minstret[63:32];
         12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
         12'h342, 12'h343, 12'h344: return m_reg[a];
         default: return (a >= 12'hB03 && a <= 12'hB0F) ? m_reg[a] : 32'h0;
      endcase
   endfunction

   // One rising edge: events first, then writes in channel order so later channels override.
   function automatic void m_step();
      logic [63:0] cyc, ins;
      logic [11:0] a;
      logic [31:0] d;
      cyc = m_mcycle + 64'd1;
      ins = m_minstret + 64'(commit_num);
      for (int k = 0; k < 13; k++) m_reg[12'hB03 + k] = m_reg[12'hB03 + k] + 32'(evt[k]);
      for (int i = 0; i < 4; i++) begin
         if (bus.commit_csrf_we[i]) begin
            a = bus.commit_csrf_write_addr[i];
            d = bus.commit_csrf_write_data[i];
            case (a)
               12'h300: m_reg[a] = (d & 32'h88) | 32'h1800;
               12'h304: m_reg[a] = d & 32'h888;
               12'h305, 12'h340, 12'h342, 12'h343: m_reg[a] = d;
               12'h341: m_reg[a] = d & ~32'h3;
               12'hB00: cyc[31:0]  = d;
               12'hB80: cyc[63:32] = d;
               12'hB02: ins[31:0]  = d;
               12'hB82: ins[63:32] = d;
               default: if (a >= 12'hB03 && a <= 12'hB0F) m_reg[a] = d;
            endcase
         end
      end
      m_reg[12'h344] = intif_mip & 32'h888;
      m_mcycle   = cyc;
      m_minstret = ins;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      check("exec_rd", bus.csrf_excsr_data, m_read(bus.excsr_csrf_addr));
      for (int i = 0; i < 4; i++)
         check($sformatf("commit_rd%0d@%h", i, bus.commit_csrf_read_addr[i]),
               bus.csrf_commit_read_data[i], m_read(bus.commit_csrf_read_addr[i]));
      check("all_mstatus", all_mstatus, m_reg[12'h300]);
      check("all_mie", all_mie, m_reg[12'h304]);
      check("all_mip", all_mip, m_reg[12'h344]);
      check("all_mepc", all_mepc, m_reg[12'h341]);
   endtask

   // Checks the current state mid-cycle, advances the model on the edge, returns 1 after it.
   task automatic tick();
      @(negedge clk);
      check_all();
      @(posedge clk);
      if (!rst) m_step();
      #1;
   endtask

   task automatic clear_bus();
      bus.excsr_csrf_addr = '0;
      bus.commit_csrf_we  = '0;
      for (int i = 0; i < 4; i++) begin
         bus.commit_csrf_read_addr[i]  = '0;
         bus.commit_csrf_write_addr[i] = '0;
         bus.commit_csrf_write_data[i] = '0;
      end
      evt        = '0;
      commit_num = '0;
   endtask

   logic [11:0] addr_tab [0:31];

   function automatic logic [11:0] pick_addr();
      if ($urandom_range(0, 7) == 0) return 12'($urandom);
      return addr_tab[$urandom_range(0, 31)];
   endfunction

   task automatic drive_random();
      bus.excsr_csrf_addr = pick_addr();
      for (int i = 0; i < 4; i++) begin
         bus.commit_csrf_read_addr[i]  = pick_addr();
         bus.commit_csrf_write_addr[i] = pick_addr();
         bus.commit_csrf_write_data[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 3))
                                                                       : $urandom;
         bus.commit_csrf_we[i] = ($urandom_range(0, 3) == 0);
      end
      evt        = 13'($urandom);
      commit_num = 3'($urandom_range(0, 4));
      intif_mip  = $urandom;
   endtask

   initial begin
      addr_tab = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                   12'h344, 12'hF11, 12'hF14, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00,
                   12'hC80, 12'hC02, 12'hC82, 12'hB03, 12'hB05, 12'hB08, 12'hB0A, 12'hB0C,
                   12'hB0F, 12'hB83, 12'hB01, 12'h123, 12'hB03, 12'hB00, 12'h341, 12'h300};
      rst = 1'b1;
      intif_mip = '0;
      clear_bus();
      m_reset();
      repeat (2) @(posedge clk);
      #1;
      bus.excsr_csrf_addr = 12'h301;
      bus.commit_csrf_read_addr[0] = 12'h123;
      #1;
      check("rst_mstatus", all_mstatus, 32'h1800);
      check("rst_mie", all_mie, 32'h0);
      check("rst_mip", all_mip, 32'h0);
      check("rst_mepc", all_mepc, 32'h0);
      check("rst_misa", bus.csrf_excsr_data, 32'h4000_1100);
      check("rst_unimpl", bus.csrf_commit_read_data[0], 32'h0);
      tick();
      rst = 1'b0;

      // mepc write: old value in the write cycle, low bits cleared afterwards
      clear_bus();
      bus.commit_csrf_we[0] = 1'b1;
      bus.commit_csrf_write_addr[0] = 12'h341;
      bus.commit_csrf_write_data[0] = 32'h8000_0007;
      bus.excsr_csrf_addr = 12'h341;
      #1;
      check("mepc_same_cycle", bus.csrf_excsr_data, 32'h0);
      tick();
      clear_bus();
      bus.excsr_csrf_addr = 12'h341;
      for (int i = 0; i < 4; i++) bus.commit_csrf_read_addr[i] = 12'h341;
      #1;
      check("mepc_exec", bus.csrf_excsr_data, 32'h8000_0004);
      for (int i = 0; i < 4; i++) check("mepc_commit", bus.csrf_commit_read_data[i], 32'h8000_0004);
      check("mepc_live", all_mepc, 32'h8000_0004);
      tick();

      // same-CSR collision and mie mask
      clear_bus();
      bus.commit_csrf_we = 4'b1011;
      bus.commit_csrf_write_addr[1] = 12'h340; bus.commit_csrf_write_data[1] = 32'h11;
      bus.commit_csrf_write_addr[3] = 12'h340; bus.commit_csrf_write_data[3] = 32'h33;
      bus.commit_csrf_write_addr[0] = 12'h304; bus.commit_csrf_write_data[0] = 32'hFFFF_FFFF;
      tick();
      clear_bus();
      bus.excsr_csrf_addr = 12'h340;
      bus.commit_csrf_read_addr[0] = 12'h304;
      #1;
      check("mscratch_ch3_wins", bus.csrf_excsr_data, 32'h33);
      check("mie_mask", bus.csrf_commit_read_data[0], 32'h888);
      tick();

      // mip follows input one cycle later, commit writes ignored
      intif_mip = 32'hFFFF_FFFF;
      tick();
      bus.commit_csrf_we[2] = 1'b1;
      bus.commit_csrf_write_addr[2] = 12'h344;
      bus.excsr_csrf_addr = 12'h344;
      #1;
      check("mip_lag", bus.csrf_excsr_data, 32'h888);
      tick();
      check("mip_write_ignored", all_mip, 32'h888);
      intif_mip = '0;
      clear_bus();

      // asynchronous reset mid-cycle, then counter increments
      rst = 1'b1;
      #1;
      m_reset();
      bus.excsr_csrf_addr = 12'hB00;
      bus.commit_csrf_read_addr[0] = 12'h340;
      #1;
      check("async_rst_mcycle", bus.csrf_excsr_data, 32'h0);
      check("async_rst_mscratch", bus.csrf_commit_read_data[0], 32'h0);
      tick();
      tick();
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         commit_num = 3'd4;
         evt[5] = (c < 2);
         tick();
      end
      clear_bus();
      bus.excsr_csrf_addr = 12'hB02;
      bus.commit_csrf_read_addr[0] = 12'hB08;
      bus.commit_csrf_read_addr[1] = 12'hC00;
      #1;
      check("minstret_12", bus.csrf_excsr_data, 32'd12);
      check("hpm8_2", bus.csrf_commit_read_data[0], 32'd2);
      check("cycle_alias", bus.csrf_commit_read_data[1], 32'd3);
      tick();

      // hpm counter wrap-around
      clear_bus();
      bus.commit_csrf_we[0] = 1'b1;
      bus.commit_csrf_write_addr[0] = 12'hB03;
      bus.commit_csrf_write_data[0] = 32'hFFFF_FFFF;
      tick();
      clear_bus();
      evt[0] = 1'b1;
      bus.excsr_csrf_addr = 12'hB03;
      #1;
      check("hpm3_written", bus.csrf_excsr_data, 32'hFFFF_FFFF);
      tick();
      check("hpm3_wrap", bus.csrf_excsr_data, 32'h0);
      tick();
      evt[0] = 1'b0;
      #1;
      check("hpm3_after_wrap", bus.csrf_excsr_data, 32'h1);
      tick();

      // 64-bit carry out of a written low half
      clear_bus();
      bus.commit_csrf_we = 4'b1100;
      bus.commit_csrf_write_addr[3] = 12'hB00; bus.commit_csrf_write_data[3] = 32'hFFFF_FFFF;
      bus.commit_csrf_write_addr[2] = 12'hB80; bus.commit_csrf_write_data[2] = 32'h5;
      tick();
      clear_bus();
      bus.excsr_csrf_addr = 12'hB80;
      bus.commit_csrf_read_addr[0] = 12'hB00;
      #1;
      check("mcycleh_written", bus.csrf_excsr_data, 32'h5);
      tick();
      check("mcycleh_carry", bus.csrf_excsr_data, 32'h6);
      check("mcycle_wrapped", bus.csrf_commit_read_data[0], 32'h0);
      tick();

      // randomized traffic against the model
      for (int c = 0; c < 400; c++) begin
         drive_random();
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/csrfile.md
# csrfile

Machine-mode control and status register file of the RV32 out-of-order core. Serves one combinational read port for the execute CSR unit and four read/write channels for commit. Holds trap, interrupt and performance-counter state, and exports mstatus/mie/mip/mepc continuously to the interrupt and trap logic.

## Interface
- `CSR_ADDR_WIDTH`, 12: CSR address width.
- `REG_DATA_WIDTH`, 32: CSR data width.
- `COMMIT_CSR_CHANNEL_NUM`, 4: commit read/write channels.
- `COMMIT_WIDTH`, 4: maximum instructions retired per cycle.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — asynchronous reset, active-high.
- `excsr_csrf_addr`  in  12  — execute-stage read address.
- `csrf_excsr_data`  out  32  — execute-stage read data.
- `commit_csrf_read_addr[0:3]`  in  12 each  — commit read addresses.
- `csrf_commit_read_data[0:3]`  out  32 each  — commit read data.
- `commit_csrf_write_addr[0:3]`  in  12 each  — commit write addresses.
- `commit_csrf_write_data[0:3]`  in  32 each  — commit write data.
- `commit_csrf_we`  in  4  — per-channel write enables.
- `intif_csrf_mip_data`  in  32  — pending-interrupt vector from the interrupt interface.
- `csrf_all_mie_data`, `csrf_all_mstatus_data`, `csrf_all_mip_data`, `csrf_all_mepc_data`  out  32 each  — live register values.
- Event inputs, 1 bit each, in the order of counters 3..15:
  - `fetch_csrf_checkpoint_buffer_full_add`, `fetch_csrf_fetch_not_full_add`, `fetch_csrf_fetch_decode_fifo_full_add`
  - `decode_csrf_decode_rename_fifo_full_add`
  - `rename_csrf_phy_regfile_full_add`, `rename_csrf_rob_full_add`
  - `issue_csrf_issue_execute_fifo_full_add`, `issue_csrf_issue_queue_full_add`
  - `commit_csrf_branch_num_add`, `commit_csrf_branch_predicted_add`, `commit_csrf_branch_hit_add`, `commit_csrf_branch_miss_add`
  - `ras_csrf_ras_full_add`
- `commit_csrf_commit_num_add`  in  3  — number of instructions retired this cycle (0..4).

## Operation
Implemented CSRs, with reset value and write mask:

- **Read-only identity**
  - misa 0x301: constant 0x40001100.
  - mvendorid 0xF11, marchid 0xF12, mimpid 0xF13, mhartid 0xF14: constant 0.
- **Trap and interrupt state**
  - mstatus 0x300: reset 0x00001800. Writable bits are MIE[3] and MPIE[7]. MPP[12:11] is hardwired to 11. All other bits read 0.
  - mie 0x304: reset 0. Write mask 0x888.
  - mtvec 0x305, mscratch 0x340, mcause 0x342, mtval 0x343: reset 0, fully writable.
  - mepc 0x341: reset 0. Bits [1:0] are forced to 0.
  - mip 0x344: reset 0. Loaded every cycle with `intif_csrf_mip_data & 0x888`. Commit writes to mip are ignored.
- **Counters**
  - mcycle 0xB00 / mcycleh 0xB80: 64-bit. Increments by 1 every cycle out of reset.
  - minstret 0xB02 / minstreth 0xB82: 64-bit. Increments by `commit_csrf_commit_num_add` each cycle.
  - cycle/cycleh (0xC00/0xC80) and instret/instreth (0xC02/0xC82) are read-only aliases of mcycle and minstret.
  - mhpmcounter3..15 (0xB03..0xB0F): 32-bit, reset 0. Counter 3+k increments by 1 when event input k (order listed above) is 1 in that cycle. Counters wrap modulo 2^32.
  - Commit writes to the mhpmcounter addresses are honoured. Their high halves are unimplemented.
- **Unimplemented addresses:** read 0; writes are ignored.
- **Reads:** all five read ports are purely combinational from current register state. There is no bypass of same-cycle writes.
- **Writes:** a channel with `we[i]=1` updates its CSR at the next rising edge, after applying that CSR's write mask.
  - If several channels write the same CSR in one cycle, the highest channel index wins.
  - Writes to different CSRs in the same cycle all take effect.
- **Write vs. increment:** if a counter half is written in the same cycle it would increment, the written value is loaded and that cycle's increment is dropped. The other half of a 64-bit counter still carries normally, based on the pre-write value.
- **Live outputs:** `csrf_all_*` outputs equal the current register values (post-mask) at all times.

## Timing
- Reads have zero latency (same-cycle combinational). Writes are visible on the cycle after the enabling edge.
- While `rst` is high, all registers and outputs hold their reset values immediately:
  - `csrf_all_mstatus_data` = 0x1800.
  - `csrf_all_mie_data`, `csrf_all_mip_data`, `csrf_all_mepc_data` = 0.
  - Read ports return the reset values of the addressed CSRs.
  - Counters do not advance.
- Asserting `rst` mid-operation clears all state asynchronously. The first mcycle increment occurs at the first rising edge after `rst` deasserts.
- mip lags `intif_csrf_mip_data` by exactly one cycle.
- 64-bit counters carry from the low half into the high half on the same edge, e.g. 0x0000_0000_FFFF_FFFF + 1 gives 0x0000_0001_0000_0000.

## Test plan
- Reset, then 0 wait cycles: mstatus output 0x1800, mie/mip/mepc outputs 0. A read of 0x301 returns 0x40001100 and a read of 0x123 returns 0.
- Channel 0 writes mepc = 0x8000_0007, then read on the next cycle: mepc reads 0x8000_0004 on all read ports and on `csrf_all_mepc_data`. A read in the write cycle itself returns the old value.
- Channels 1 and 3 write mscratch = 0x11 and 0x33 in the same cycle: the next cycle reads 0x33. mie written with 0xFFFFFFFF reads 0x888.
- `intif_csrf_mip_data` = 0xFFFF_FFFF for one cycle: mip reads 0x888 on the next cycle. A commit write to mip of 0 the following cycle has no effect while the input is held.
- `commit_csrf_commit_num_add` = 4 for 3 cycles plus `rename_csrf_rob_full_add` = 1 for 2 cycles: minstret = 12 and mhpmcounter8 (0xB08) = 2.
- mhpmcounter3 written with 0xFFFF_FFFF, then its event held high for 2 cycles: it reads 0, then 1 (wrap-around).
